// File: rtl/bridge_pkg.sv
// Shared bridge items: frame characters, transmit FSM states, counter sizing.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bridge_pkg;

    localparam logic [7:0] PREAMBLE_CHAR = 8'h4D;  // 'M'
    localparam logic [7:0] CR_CHAR       = 8'h0D;
    localparam logic [7:0] LF_CHAR       = 8'h0A;

    // Each state names the byte currently presented on the output.
    typedef enum logic [2:0] {
        IDLE,
        PRE,
        ADDR,
        DATA,
        CR,
        LF
    } bridge_tx_state_t;

    // Width of a counter indexing the nibbles of the wider field.
    // Kept at least 1 bit so a single-nibble field still has a legal vector.
    function automatic int cnt_width(input int aw, input int dw);
        int n;
        n = ((aw > dw) ? aw : dw) / 4;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/nibble_to_ascii.sv
// Combinational hex-digit encoder: 0-9 -> '0'-'9', 10-15 -> 'A'-'F'.
// Latency: zero cycles (pure combinational).
// Backpressure: none; output follows input.
// Ports: i_nib (4-bit value), o_ascii (uppercase ASCII hex digit).
module nibble_to_ascii (
    input  logic [3:0] i_nib,
    output logic [7:0] o_ascii
);

    // 'A' (8'h41) minus 10 is 8'h37.
    always_comb begin
        if (i_nib < 4'd10) begin
            o_ascii = 8'h30 + {4'h0, i_nib};
        end else begin
            o_ascii = 8'h37 + {4'h0, i_nib};
        end
    end

endmodule

// File: rtl/bridge_req_tx.sv
// Request encoder: serialises one addr/wdata/rw request into "M<addr>[<wdata>]\r\n".
// Latency: accept at cycle N, 'M' registered on data_o at N+1; one byte per handshake.
// Backpressure: data_o/valid_o held while !ready_i; ready_o high only in IDLE (no queueing).
// Ports: clk, rst (async active-high); request side addr_i/wdata_i/rw_i/valid_i/ready_o;
//        byte side data_o/valid_o/ready_i.
module bridge_req_tx
    import bridge_pkg::*;
#(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  rw_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [7:0]            data_o,
    output logic                  valid_o,
    input  logic                  ready_i
);

    localparam int ADDR_NIB = ADDR_WIDTH / 4;
    localparam int DATA_NIB = DATA_WIDTH / 4;
    localparam int CNT_W    = cnt_width(ADDR_WIDTH, DATA_WIDTH);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_NIB - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_NIB - 1);

    bridge_tx_state_t      r_state;
    bridge_tx_state_t      w_state_nxt;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      w_cnt_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic                  r_rw;
    logic [7:0]            r_data;
    logic [7:0]            w_data_nxt;
    logic                  r_valid;
    logic                  w_accept;
    logic                  w_hs;
    logic [3:0]            w_nib;
    logic [7:0]            w_nib_ascii;

    assign ready_o  = (r_state == IDLE);
    assign w_accept = valid_i && ready_o;
    assign w_hs     = r_valid && ready_i;
    assign data_o   = r_data;
    assign valid_o  = r_valid;

    // Next state / nibble index. Without a handshake everything holds,
    // which is what keeps data_o stable under backpressure.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = PRE;
                end
            end
            PRE: begin
                if (w_hs) begin
                    w_state_nxt = ADDR;
                    w_cnt_nxt   = '0;
                end
            end
            ADDR: begin
                if (w_hs) begin
                    if (r_cnt == ADDR_LAST) begin
                        w_state_nxt = r_rw ? DATA : CR;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (w_hs) begin
                    if (r_cnt == DATA_LAST) begin
                        w_state_nxt = CR;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            CR: begin
                if (w_hs) begin
                    w_state_nxt = LF;
                end
            end
            LF: begin
                if (w_hs) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Pick the nibble the next byte will carry, MSB nibble first. Fields are
    // read from the latched copies, which are stable for the whole frame.
    always_comb begin
        w_nib = 4'h0;
        if (w_state_nxt == ADDR) begin
            for (int k = 0; k < ADDR_NIB; k++) begin
                if (k == int'(w_cnt_nxt)) begin
                    w_nib = r_addr[4*(ADDR_NIB-1-k) +: 4];
                end
            end
        end else if (w_state_nxt == DATA) begin
            for (int k = 0; k < DATA_NIB; k++) begin
                if (k == int'(w_cnt_nxt)) begin
                    w_nib = r_wdata[4*(DATA_NIB-1-k) +: 4];
                end
            end
        end
    end

    nibble_to_ascii u_nib_enc (
        .i_nib   (w_nib),
        .o_ascii (w_nib_ascii)
    );

    // The output byte is a pure function of the next state and index, so a
    // held state regenerates the same byte. In IDLE the last byte is left in
    // place with valid low.
    always_comb begin
        w_data_nxt = r_data;
        case (w_state_nxt)
            PRE:       w_data_nxt = PREAMBLE_CHAR;
            ADDR,
            DATA:      w_data_nxt = w_nib_ascii;
            CR:        w_data_nxt = CR_CHAR;
            LF:        w_data_nxt = LF_CHAR;
            default:   w_data_nxt = r_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_data  <= 8'h00;
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rw    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_data  <= w_data_nxt;
            r_valid <= (w_state_nxt != IDLE);
            if (w_accept) begin
                r_addr  <= addr_i;
                r_wdata <= wdata_i;
                r_rw    <= rw_i;
            end
        end
    end

endmodule

// File: tb/tb_bridge_req_tx.sv
// Bench for bridge_req_tx: directed frames, busy/back-to-back/reset cases, random requests.
// Latency: checks 'M' one cycle after accept and a 7-cycle read frame with ready_i held high.
// Backpressure: ready_i randomised in the final phase; hold rule checked every cycle.
module tb_bridge_req_tx;

    logic        clk     = 1'b0;
    logic        rst     = 1'b1;
    logic [15:0] addr_i  = 16'h0;
    logic [15:0] wdata_i = 16'h0;
    logic        rw_i    = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_i = 1'b1;
    logic        ready_o;
    logic        valid_o;
    logic [7:0]  data_o;

    int          n_cmp  = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  got_q[$];
    bit          bp_mode    = 1'b0;
    bit          lf_seen    = 1'b0;
    bit          prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;

    bridge_req_tx #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (16)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rw_i    (rw_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .data_o  (data_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected frame built as text: 'M', hex digits of addr, optional hex
    // digits of wdata, then CR LF.
    task automatic model_frame(input logic [15:0] a, input logic [15:0] w, input logic r);
        string hexd;
        hexd = "0123456789ABCDEF";
        exp_q.push_back("M");
        for (int i = 3; i >= 0; i--) exp_q.push_back(hexd[int'((a >> (4 * i)) & 16'hF)]);
        if (r) begin
            for (int i = 3; i >= 0; i--) exp_q.push_back(hexd[int'((w >> (4 * i)) & 16'hF)]);
        end
        exp_q.push_back(8'h0D);
        exp_q.push_back(8'h0A);
    endtask

    // Present a request until accepted, then scramble the inputs to show
    // the frame uses the latched values. Returns at the negedge after accept.
    task automatic issue(input logic [15:0] a, input logic [15:0] w, input logic r);
        int t;
        t = 0;
        @(posedge clk); #1;
        addr_i = a; wdata_i = w; rw_i = r; valid_i = 1'b1;
        @(negedge clk);
        while (!ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("accept_timeout", 32'(t < 100), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        addr_i  = 16'($urandom);
        wdata_i = 16'($urandom);
        rw_i    = 1'($urandom_range(0, 1));
        model_frame(a, w, r);
        @(negedge clk);
        check("first_valid", 32'(valid_o), 32'd1);
        check("first_byte", 32'(data_o), 32'h4D);
        check("busy_ready", 32'(ready_o), 32'd0);
    endtask

    task automatic drain(input string tag);
        int t;
        t = 0;
        while (got_q.size() < exp_q.size() && t < 400) begin
            @(negedge clk); #1;
            t++;
        end
        check({tag, "_timeout"}, 32'(t < 400), 32'd1);
        check({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
        end
        got_q.delete();
        exp_q.delete();
    endtask

    // ready_i driver: always ready, or a coin flip per cycle.
    initial begin
        forever begin
            @(posedge clk); #1;
            ready_i = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Byte monitor: collects handshaken bytes, checks the hold rule, that
    // valid_o and ready_o are never both high, and the idle cycle after LF.
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 1'b0;
                lf_seen    = 1'b0;
            end else begin
                if (lf_seen) begin
                    check("post_lf_ready", 32'(ready_o), 32'd1);
                    check("post_lf_valid", 32'(valid_o), 32'd0);
                    lf_seen = 1'b0;
                end
                if (prev_stall) begin
                    check("hold_valid", 32'(valid_o), 32'd1);
                    check("hold_data", 32'(data_o), 32'(prev_data));
                end
                if (valid_o) check("valid_vs_ready", 32'(ready_o), 32'd0);
                if (valid_o && ready_i) begin
                    got_q.push_back(data_o);
                    if (data_o == 8'h0A) lf_seen = 1'b1;
                end
                prev_stall = valid_o && !ready_i;
                prev_data  = data_o;
            end
        end
    end

    initial begin
        int c;
        int t;
        logic [15:0] ra;
        logic [15:0] rd;
        logic        rr;

        // Reset values.
        repeat (3) @(negedge clk);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_valid", 32'(valid_o), 32'd0);
        check("rst_data", 32'(data_o), 32'h00);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("idle_valid", 32'(valid_o), 32'd0);

        // Read frame: 7 consecutive bytes with ready_i high.
        issue(16'h1234, 16'h0000, 1'b0);
        c = 1;
        while (got_q.size() < 7 && c < 50) begin
            @(negedge clk); #1;
            c++;
        end
        check("read_cycles", 32'(c), 32'd7);
        drain("read");

        // Write frame.
        issue(16'h1234, 16'hABCD, 1'b1);
        drain("write");

        // Busy ignore: a pulse mid-frame must not start another frame.
        issue(16'hC0DE, 16'h9F3A, 1'b1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        addr_i = 16'h0001; rw_i = 1'b0; valid_i = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0;
        drain("busy");
        repeat (6) @(negedge clk);
        check("busy_no_extra", 32'(got_q.size()), 32'd0);

        // Request held across the final LF: taken only after the idle cycle.
        issue(16'h00FF, 16'h0000, 1'b0);
        addr_i = 16'hBEEF; wdata_i = 16'h0123; rw_i = 1'b1; valid_i = 1'b1;
        model_frame(16'hBEEF, 16'h0123, 1'b1);
        t = 0;
        @(negedge clk);
        while (!ready_o && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("b2b_wait", 32'(t < 100), 32'd1);
        @(posedge clk); #1;
        valid_i = 1'b0;
        drain("b2b");

        // Reset mid-frame, then a clean read of 0x0000.
        issue(16'h1234, 16'h0000, 1'b0);
        #1 rst = 1'b1;
        #1;
        check("midrst_valid", 32'(valid_o), 32'd0);
        check("midrst_ready", 32'(ready_o), 32'd1);
        check("midrst_data", 32'(data_o), 32'h00);
        repeat (2) @(negedge clk);
        got_q.delete();
        exp_q.delete();
        #2 rst = 1'b0;
        repeat (4) @(negedge clk);
        check("postrst_no_bytes", 32'(got_q.size()), 32'd0);
        check("postrst_valid", 32'(valid_o), 32'd0);
        issue(16'h0000, 16'h0000, 1'b0);
        drain("postrst");

        // Random requests under random backpressure.
        bp_mode = 1'b1;
        for (int n = 0; n < 30; n++) begin
            ra = 16'($urandom);
            rd = 16'($urandom);
            rr = 1'($urandom_range(0, 1));
            issue(ra, rd, rr);
            drain($sformatf("rnd%0d", n));
        end
        bp_mode = 1'b0;
        repeat (4) @(negedge clk);
        check("end_idle", 32'(ready_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
